// File: rtl/tans_bit_packer_if.sv
// Code-stream and word-stream signals of the tANS bit packer.
// slave = the packer itself; master = recoder/sink side. TANS_PACK_BITCOUNT_EN adds o_bit_count.
interface tans_bit_packer_if #(
    parameter int WORD_W  = 8,
    parameter int CODE_W  = 3,
    parameter int CNT_W   = 2,
    parameter int STATE_W = 4
);
    localparam int NB_W = $clog2(WORD_W + 1);

    logic                I_F;
    logic                i_val;
    logic                i_rdy;
    logic [CNT_W-1:0]    BTR;
    logic [CODE_W-1:0]   o_stream;
    logic                FIN;
    logic [STATE_W-1:0]  final_state;
    logic [WORD_W-1:0]   o_word;
    logic [NB_W-1:0]     o_nbits;
    logic                o_last;
    logic                o_valid;
    logic                o_ready;
`ifdef TANS_PACK_BITCOUNT_EN
    logic [31:0]         o_bit_count;

    modport slave (
        input  I_F, i_val, BTR, o_stream, FIN, final_state, o_ready,
        output i_rdy, o_word, o_nbits, o_last, o_valid, o_bit_count
    );
    modport master (
        output I_F, i_val, BTR, o_stream, FIN, final_state, o_ready,
        input  i_rdy, o_word, o_nbits, o_last, o_valid, o_bit_count
    );
`else
    modport slave (
        input  I_F, i_val, BTR, o_stream, FIN, final_state, o_ready,
        output i_rdy, o_word, o_nbits, o_last, o_valid
    );
    modport master (
        output I_F, i_val, BTR, o_stream, FIN, final_state, o_ready,
        input  i_rdy, o_word, o_nbits, o_last, o_valid
    );
`endif
endinterface

// File: rtl/tans_bit_packer.sv
// Packs variable-length tANS codes LSB-first into WORD_W-bit words, appends the final state and flushes.
// Optional TANS_PACK_BITCOUNT_EN builds the per-block payload bit counter (o_bit_count).
module tans_bit_packer #(
    parameter int WORD_W  = 8,
    parameter int CODE_W  = 3,
    parameter int CNT_W   = 2,
    parameter int STATE_W = 4
) (
    input  logic              PHI,
    input  logic              RST,
    tans_bit_packer_if.slave  bus
);
    localparam int EXT_W  = (STATE_W > CODE_W) ? STATE_W : CODE_W;
    localparam int ACC_W  = WORD_W + EXT_W;
    localparam int FILL_W = $clog2(ACC_W + 1);
    localparam int NB_W   = $clog2(WORD_W + 1);

    localparam logic [FILL_W-1:0] WORD_FILL = FILL_W'(WORD_W);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_TAIL  = 2'd2;
    localparam logic [1:0] ST_FLUSH = 2'd3;

    logic [1:0]         state_reg,  state_next;
    logic [ACC_W-1:0]   acc_reg,    acc_next;
    logic [FILL_W-1:0]  fill_reg,   fill_next;
    logic [STATE_W-1:0] fstate_reg, fstate_next;
    logic [WORD_W-1:0]  word_reg,   word_next;
    logic [NB_W-1:0]    nbits_reg,  nbits_next;
    logic               last_reg,   last_next;
    logic               valid_reg,  valid_next;
    logic               alive_reg;

    logic               rdy;
    logic               pop;
    logic               accept;
    logic               clr_count;
    logic               flushing;
    logic [FILL_W-1:0]  btr_eff;
    logic [CODE_W-1:0]  code_bits;
    logic [WORD_W-1:0]  fill_mask;
    logic [ACC_W-1:0]   acc_base;
    logic [FILL_W-1:0]  fill_base;
    logic [ACC_W-1:0]   ins_bits;
    logic [FILL_W-1:0]  ins_len;

    genvar gi;

    // alive_reg keeps i_rdy low while reset is held and for the edge that releases it
    always_comb begin
        rdy = 1'b0;
        if (alive_reg) begin
            case (state_reg)
                ST_IDLE: rdy = 1'b1;
                ST_RUN:  rdy = (fill_reg < WORD_FILL);
                default: rdy = 1'b0;
            endcase
        end
    end

    assign bus.i_rdy = rdy;

    assign btr_eff = (32'(bus.BTR) > CODE_W) ? FILL_W'(CODE_W) : FILL_W'(bus.BTR);

    // Bits of o_stream above the code length never reach the accumulator
    generate
        for (gi = 0; gi < CODE_W; gi++) begin : g_code_mask
            assign code_bits[gi] = bus.o_stream[gi] & (btr_eff > FILL_W'(gi));
        end
    endgenerate

    always_comb begin
        pop         = valid_reg & bus.o_ready;
        accept      = rdy & bus.i_val;
        acc_base    = pop ? (acc_reg >> WORD_W) : acc_reg;
        fill_base   = fill_reg;
        if (pop) begin
            fill_base = (fill_reg > WORD_FILL) ? (fill_reg - WORD_FILL) : '0;
        end
        state_next  = state_reg;
        fstate_next = fstate_reg;
        ins_bits    = '0;
        ins_len     = '0;
        clr_count   = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (accept && bus.I_F) begin
                    ins_bits   = ACC_W'(code_bits);
                    ins_len    = btr_eff;
                    clr_count  = 1'b1;
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (accept) begin
                    ins_bits = ACC_W'(code_bits);
                    ins_len  = btr_eff;
                    if (bus.FIN) begin
                        fstate_next = bus.final_state;
                        state_next  = ST_TAIL;
                    end
                end
            end
            ST_TAIL: begin
                // Wait until the pending full word has drained before appending the state
                if (fill_reg < WORD_FILL) begin
                    ins_bits   = ACC_W'(fstate_reg);
                    ins_len    = FILL_W'(STATE_W);
                    state_next = ST_FLUSH;
                end
            end
            default: begin
                if (fill_base == '0) begin
                    state_next = ST_IDLE;
                end
            end
        endcase

        acc_next  = acc_base | (ins_bits << fill_base);
        fill_next = fill_base + ins_len;
    end

    generate
        for (gi = 0; gi < WORD_W; gi++) begin : g_fill_mask
            assign fill_mask[gi] = (fill_next > FILL_W'(gi));
        end
    endgenerate

    // Output registers follow the post-update accumulator, so they stay put while stalled
    always_comb begin
        flushing   = (state_next == ST_FLUSH);
        valid_next = flushing ? (fill_next != '0) : (fill_next >= WORD_FILL);
        last_next  = flushing && (fill_next <= WORD_FILL);
        nbits_next = NB_W'(WORD_W);
        if (flushing && (fill_next < WORD_FILL)) begin
            nbits_next = NB_W'(fill_next);
        end
        word_next  = acc_next[WORD_W-1:0] & fill_mask;
    end

    always_ff @(posedge PHI or posedge RST) begin
        if (RST) begin
            state_reg  <= ST_IDLE;
            acc_reg    <= '0;
            fill_reg   <= '0;
            fstate_reg <= '0;
            word_reg   <= '0;
            nbits_reg  <= '0;
            last_reg   <= 1'b0;
            valid_reg  <= 1'b0;
            alive_reg  <= 1'b0;
        end else begin
            state_reg  <= state_next;
            acc_reg    <= acc_next;
            fill_reg   <= fill_next;
            fstate_reg <= fstate_next;
            word_reg   <= word_next;
            nbits_reg  <= nbits_next;
            last_reg   <= last_next;
            valid_reg  <= valid_next;
            alive_reg  <= 1'b1;
        end
    end

    assign bus.o_word  = word_reg;
    assign bus.o_nbits = nbits_reg;
    assign bus.o_last  = last_reg;
    assign bus.o_valid = valid_reg;

`ifdef TANS_PACK_BITCOUNT_EN
    logic [31:0] bit_count_reg;

    // Restarts with the first code of a block; padding never enters ins_len
    always_ff @(posedge PHI or posedge RST) begin
        if (RST) begin
            bit_count_reg <= '0;
        end else if (clr_count) begin
            bit_count_reg <= 32'(ins_len);
        end else begin
            bit_count_reg <= bit_count_reg + 32'(ins_len);
        end
    end

    assign bus.o_bit_count = bit_count_reg;
`else
    logic unused_clr;
    assign unused_clr = clr_count;
`endif

endmodule

// File: tb/tb_tans_bit_packer.sv
// Directed bench for tans_bit_packer: hand-computed words checked through a single check task.
module tb_tans_bit_packer;
    localparam int WORD_W  = 8;
    localparam int CODE_W  = 3;
    localparam int CNT_W   = 2;
    localparam int STATE_W = 4;

    logic PHI = 1'b0;
    logic RST;
    int   n_checks = 0;
    int   n_errors = 0;
    logic [15:0] words_q[$];

    always #5 PHI = ~PHI;

    tans_bit_packer_if #(.WORD_W(WORD_W), .CODE_W(CODE_W), .CNT_W(CNT_W), .STATE_W(STATE_W)) bus ();

    tans_bit_packer #(.WORD_W(WORD_W), .CODE_W(CODE_W), .CNT_W(CNT_W), .STATE_W(STATE_W)) dut (
        .PHI (PHI),
        .RST (RST),
        .bus (bus)
    );

    // Every popped word as {3'b0, last, nbits[3:0], word[7:0]}
    always @(negedge PHI) begin
        if (!RST && bus.o_valid && bus.o_ready) begin
            words_q.push_back({3'b000, bus.o_last, bus.o_nbits, bus.o_word});
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge PHI);
        #1;
    endtask

    task automatic drive_idle();
        bus.I_F         = 1'b0;
        bus.i_val       = 1'b0;
        bus.BTR         = '0;
        bus.o_stream    = '0;
        bus.FIN         = 1'b0;
        bus.final_state = '0;
    endtask

    task automatic do_reset();
        drive_idle();
        bus.o_ready = 1'b0;
        RST = 1'b1;
        tick();
        tick();
        RST = 1'b0;
        tick();
        words_q.delete();
    endtask

    task automatic send_code(input logic f, input logic [1:0] btr, input logic [2:0] code,
                             input logic fin, input logic [3:0] st);
        int guard;
        bus.I_F         = f;
        bus.BTR         = btr;
        bus.o_stream    = code;
        bus.FIN         = fin;
        bus.final_state = st;
        bus.i_val       = 1'b1;
        guard = 0;
        while (!bus.i_rdy && guard < 100) begin
            tick();
            guard++;
        end
        if (guard >= 100) check("send_timeout", 32'(bus.i_rdy), 32'd1);
        tick();
        drive_idle();
    endtask

    task automatic wait_words(input string tag, input int n);
        int guard;
        guard = 0;
        while (words_q.size() < n && guard < 300) begin
            tick();
            guard++;
        end
        repeat (6) tick();
        check({tag, "_count"}, 32'(words_q.size()), 32'(n));
    endtask

    task automatic check_word(input string tag, input int idx, input logic [7:0] w,
                              input logic [3:0] nb, input logic l);
        logic [15:0] e;
        e = (idx < words_q.size()) ? words_q[idx] : 16'hFFFF;
        check({tag, "_word"},  32'(e[7:0]),  32'(w));
        check({tag, "_nbits"}, 32'(e[11:8]), 32'(nb));
        check({tag, "_last"},  32'(e[12]),   32'(l));
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        RST = 1'b1;
        drive_idle();
        bus.o_ready = 1'b0;

        // Asynchronous reset while a word is pending
        do_reset();
        check("t1_rdy_after_rst", 32'(bus.i_rdy), 32'd1);
        send_code(1'b1, 2'd3, 3'b111, 1'b0, 4'h0);
        send_code(1'b0, 2'd3, 3'b101, 1'b0, 4'h0);
        send_code(1'b0, 2'd3, 3'b011, 1'b0, 4'h0);
        check("t1_pending_valid", 32'(bus.o_valid), 32'd1);
        #2;
        RST = 1'b1;
        #1;
        check("t1_rst_valid", 32'(bus.o_valid), 32'd0);
        check("t1_rst_rdy",   32'(bus.i_rdy),   32'd0);
        check("t1_rst_word",  32'(bus.o_word),  32'd0);
        check("t1_rst_nbits", 32'(bus.o_nbits), 32'd0);
        check("t1_rst_last",  32'(bus.o_last),  32'd0);
        tick();
        tick();
        RST = 1'b0;
        tick();
        check("t1_rdy_release", 32'(bus.i_rdy), 32'd1);
        check("t1_valid_release", 32'(bus.o_valid), 32'd0);

        // Basic packing into one full word
        do_reset();
        bus.o_ready = 1'b1;
        send_code(1'b1, 2'd2, 3'b011, 1'b0, 4'h0);
        send_code(1'b0, 2'd3, 3'b101, 1'b0, 4'h0);
        send_code(1'b0, 2'd3, 3'b110, 1'b0, 4'h0);
        wait_words("t2", 1);
        check_word("t2", 0, 8'hD7, 4'd8, 1'b0);
`ifdef TANS_PACK_BITCOUNT_EN
        check("t2_bitcount", bus.o_bit_count, 32'd8);
`endif

        // Zero-length codes and a code dropped in IDLE without I_F
        do_reset();
        bus.o_ready = 1'b1;
        send_code(1'b0, 2'd3, 3'b111, 1'b0, 4'h0);
        send_code(1'b1, 2'd2, 3'b011, 1'b0, 4'h0);
        send_code(1'b0, 2'd0, 3'b111, 1'b0, 4'h0);
        send_code(1'b0, 2'd3, 3'b101, 1'b0, 4'h0);
        send_code(1'b0, 2'd0, 3'b010, 1'b0, 4'h0);
        send_code(1'b0, 2'd3, 3'b110, 1'b0, 4'h0);
        wait_words("t3", 1);
        check_word("t3", 0, 8'hD7, 4'd8, 1'b0);
`ifdef TANS_PACK_BITCOUNT_EN
        check("t3_bitcount", bus.o_bit_count, 32'd8);
`endif

        // Backpressure: word held, input stalled, released by o_ready
        do_reset();
        send_code(1'b1, 2'd3, 3'b111, 1'b0, 4'h0);
        send_code(1'b0, 2'd3, 3'b111, 1'b0, 4'h0);
        send_code(1'b0, 2'd3, 3'b111, 1'b0, 4'h0);
        bus.i_val    = 1'b1;
        bus.BTR      = 2'd2;
        bus.o_stream = 3'b010;
        for (int i = 0; i < 3; i++) begin
            check("t4_stall_rdy",   32'(bus.i_rdy),   32'd0);
            check("t4_stall_valid", 32'(bus.o_valid), 32'd1);
            check("t4_stall_word",  32'(bus.o_word),  32'hFF);
            tick();
        end
        bus.o_ready = 1'b1;
        tick();
        check("t4_rdy_after_pop", 32'(bus.i_rdy), 32'd1);
        tick();
        drive_idle();
        wait_words("t4", 1);
        check_word("t4", 0, 8'hFF, 4'd8, 1'b0);
`ifdef TANS_PACK_BITCOUNT_EN
        check("t4_bitcount", bus.o_bit_count, 32'd11);
`endif

        // Short block: codes + final state in one partial word
        do_reset();
        bus.o_ready = 1'b1;
        send_code(1'b1, 2'd2, 3'b001, 1'b0, 4'h0);
        send_code(1'b0, 2'd1, 3'b001, 1'b1, 4'b1001);
        wait_words("t5", 1);
        check_word("t5", 0, 8'h4D, 4'd7, 1'b1);
        check("t5_idle_rdy", 32'(bus.i_rdy), 32'd1);
`ifdef TANS_PACK_BITCOUNT_EN
        check("t5_bitcount", bus.o_bit_count, 32'd7);
`endif

        // Tail ends exactly on a word boundary; I_F in RUN ignored
        do_reset();
        bus.o_ready = 1'b1;
        send_code(1'b1, 2'd2, 3'b011, 1'b0, 4'h0);
        send_code(1'b1, 2'd2, 3'b011, 1'b1, 4'b1111);
        wait_words("t5b", 1);
        check_word("t5b", 0, 8'hFF, 4'd8, 1'b1);
`ifdef TANS_PACK_BITCOUNT_EN
        check("t5b_bitcount", bus.o_bit_count, 32'd8);
`endif

        // Long block: 16 x 3 bits, FIN on the last code, state 0000
        do_reset();
        bus.o_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            send_code(i == 0, 2'd3, 3'b111, i == 15, 4'b0000);
        end
        wait_words("t6", 7);
        for (int i = 0; i < 6; i++) begin
            check_word($sformatf("t6_w%0d", i), i, 8'hFF, 4'd8, 1'b0);
        end
        check_word("t6_w6", 6, 8'h00, 4'd4, 1'b1);
`ifdef TANS_PACK_BITCOUNT_EN
        check("t6_bitcount", bus.o_bit_count, 32'd52);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
